sync_fifo: RTL and testbench

Parametrised single-clock FIFO for system-bus request/response buffering, the next generation of the bus FIFO. Stores WIDTH-bit words in DEPTH entries with first-word-fall-through read data. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Sits between bus masters/slaves and the arbiter wherever rate decoupling is needed.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr.sv | 17 +
 rtl/sync_fifo.sv | 77 +++++++
 tb/tb_sync_fifo.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO helpers and the status bundle reused by FIFO variants and bus monitors.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping FIFO pointer; MSB is the wrap bit, low bits address memory.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy, thresholds,
// sticky overflow/underflow flags and synchronous flush.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     enq,
    input  logic                     deq,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             deq_ok, enq_ok, ovf, unf;
    fifo_status_t     st;

    assign count           = wr_ptr - rd_ptr;
    assign st.empty        = rd_ptr == wr_ptr;
    assign st.full         = rd_ptr[AW-1:0] == wr_ptr[AW-1:0] && rd_ptr[PW-1] != wr_ptr[PW-1];
    assign st.almost_full  = count >= PW'(AF_THRESH);
    assign st.almost_empty = count <= PW'(AE_THRESH);
    assign st.overflow     = ovf;
    assign st.underflow    = unf;
    assign {empty, full, almost_full, almost_empty, overflow, underflow} = st;

    // A pop frees the head slot, so a full FIFO can still accept a simultaneous push.
    assign deq_ok   = deq && !st.empty;
    assign enq_ok   = enq && (!st.full || deq_ok);
    assign data_out = mem[rd_ptr[AW-1:0]];

    fifo_ptr #(.W(PW)) u_rd (.clk(clk), .rstn(rstn), .clr(clr), .inc(deq_ok), .ptr(rd_ptr));
    fifo_ptr #(.W(PW)) u_wr (.clk(clk), .rstn(rstn), .clr(clr), .inc(enq_ok), .ptr(wr_ptr));

    always_ff @(posedge clk)
        if (enq_ok && !clr) mem[wr_ptr[AW-1:0]] <= data_in;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (enq && !enq_ok) ovf <= 1'b1;
            if (deq && !deq_ok) unf <= 1'b1;
        end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scoreboard bench for sync_fifo at DEPTH=4, AF=3, AE=1.
module tb_sync_fifo;

    localparam int W = 8;
    localparam int D = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] data_out;
    logic         empty, full, almost_full, almost_empty, overflow, underflow;
    logic [2:0]   count;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] q[$];
    logic mov = 1'b0;
    logic mun = 1'b0;

    sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .data_in(data_in), .enq(enq), .deq(deq),
        .data_out(data_out), .empty(empty), .full(full), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == D));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(mov));
        chk("underflow", 32'(underflow), 32'(mun));
        if (n != 0) chk("head", 32'(data_out), 32'(q[0]));
    endtask

    // One clock: model decides acceptance from pre-edge state, popped data checked before the edge.
    task automatic step(input logic e, input logic [W-1:0] d, input logic dq, input logic c);
        logic dok, eok;
        logic [W-1:0] exp;
        dok = dq && q.size() != 0;
        eok = e && (q.size() != D || dok);
        enq = e; data_in = d; deq = dq; clr = c;
        if (c) begin
            q.delete();
            mov = 1'b0;
            mun = 1'b0;
        end else begin
            if (dok) begin
                exp = q.pop_front();
                chk("pop_data", 32'(data_out), 32'(exp));
            end
            if (eok) q.push_back(d);
            if (e && !eok) mov = 1'b1;
            if (dq && !dok) mun = 1'b1;
        end
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0; clr = 1'b0;
        check_status();
    endtask

    initial begin
        logic [W-1:0] v;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_status();

        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + W'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + W'(i), 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'hC0, 1'b1, 1'b0);
        chk("empty_pushpop_data", 32'(data_out), 32'h0C0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        v = 8'h10;
        for (int i = 0; i < 3 * D; i++) begin
            step(1'b1, v, i >= 2, 1'b0);
            v++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), 1'b0);
            v++;
        end

        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + W'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);

        #2;
        rstn = 1'b0;
        q.delete();
        mov = 1'b0;
        mun = 1'b0;
        #1;
        check_status();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_status();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
